// File: rtl/piso_reg_tx_if.sv
// piso_reg_tx_if: load handshake and serial framing bundle for piso_reg_tx.
//   pdata/load_valid  : word offered by the sender, held until load_ready
//   load_ready        : transmitter can take a word this cycle
//   sout/sout_valid   : serial bit and its qualifier
//   sout_last         : current bit is the final bit of the word
//   busy              : word in transmission (same as sout_valid)
// master = word source / serial sink side, slave = the transmitter.
interface piso_reg_tx_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] pdata;
    logic             load_valid;
    logic             load_ready;
    logic             sout;
    logic             sout_valid;
    logic             sout_last;
    logic             busy;

    modport master (
        output pdata, load_valid,
        input  load_ready, sout, sout_valid, sout_last, busy
    );

    modport slave (
        input  pdata, load_valid,
        output load_ready, sout, sout_valid, sout_last, busy
    );
endinterface

// File: rtl/piso_reg_tx.sv
// piso_reg_tx: parallel-in serial-out transmitter, one bit per clock.
//   clk    : system clock, rising edge
//   rst_n  : synchronous active-low reset
//   io     : piso_reg_tx_if.slave (load handshake in, framed serial out)
// A word accepted at edge k shows its first bit in cycle k+1 and occupies
// exactly WIDTH sout_valid cycles. A new word can be accepted in the
// final-bit cycle so consecutive words stream with no gap.
module piso_reg_tx #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    piso_reg_tx_if.slave   io
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             accept;
    logic [WIDTH-1:0] sreg_next;

    assign last_bit = (state == SHIFT) && (cnt == LAST);
    assign accept   = io.load_valid && io.load_ready;

    // Shift toward whichever end feeds sout, zero-filling behind.
    assign sreg_next = (MSB_FIRST != 0) ? {sreg[WIDTH-2:0], 1'b0}
                                        : {1'b0, sreg[WIDTH-1:1]};

    assign io.load_ready = (state == IDLE) || last_bit;
    assign io.sout_valid = (state == SHIFT);
    assign io.busy       = (state == SHIFT);
    assign io.sout_last  = last_bit;
    assign io.sout       = (state == SHIFT) &&
                           ((MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sreg  <= io.pdata;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (accept) begin
                        // Final bit going out and next word ready: reload in place.
                        sreg <= io.pdata;
                        cnt  <= '0;
                    end else if (last_bit) begin
                        state <= IDLE;
                        sreg  <= '0;
                        cnt   <= '0;
                    end else begin
                        sreg <= sreg_next;
                        cnt  <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    sreg  <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_piso_reg_tx.sv
// tb_piso_reg_tx: bench for piso_reg_tx. A 4-bit MSB-first instance is
// checked every cycle against a word/bit-position model; an 8-bit
// LSB-first instance is checked by loopback into a small SIPO.
module tb_piso_reg_tx;
    localparam int W4 = 4;

    logic clk;
    logic rst_n;
    logic chk_en;
    int   errs;
    int   checks;

    piso_reg_tx_if #(.WIDTH(4)) a ();
    piso_reg_tx_if #(.WIDTH(8)) b ();

    piso_reg_tx #(.WIDTH(4), .MSB_FIRST(1)) dut4 (.clk(clk), .rst_n(rst_n), .io(a));
    piso_reg_tx #(.WIDTH(8), .MSB_FIRST(0)) dut8 (.clk(clk), .rst_n(rst_n), .io(b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: the word in flight and which bit position of it is on the wire.
    int         pos;
    logic [3:0] cur;
    initial begin
        pos = -1;
        cur = '0;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            pos = -1;
        end else if (a.load_valid && (pos < 0 || pos == W4 - 1)) begin
            cur = a.pdata;
            pos = 0;
        end else if (pos >= 0) begin
            pos = pos + 1;
            if (pos == W4) pos = -1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic m_bit;
            m_bit = (pos < 0) ? 1'b0 : cur[W4 - 1 - pos];
            chk("m_sout",       32'(a.sout),       32'(m_bit));
            chk("m_sout_valid", 32'(a.sout_valid), 32'(pos >= 0));
            chk("m_busy",       32'(a.busy),       32'(pos >= 0));
            chk("m_sout_last",  32'(a.sout_last),  32'(pos == W4 - 1));
            chk("m_load_ready", 32'(a.load_ready), 32'(pos < 0 || pos == W4 - 1));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [8:0] e_sout, e_vld, e_last, e_rdy;
        int         bits8 [8];
        logic [7:0] sipo;

        errs = 0; checks = 0; chk_en = 1'b0;
        rst_n = 1'b0;
        a.load_valid = 1'b0; a.pdata = '0;
        b.load_valid = 1'b0; b.pdata = '0;
        repeat (2) step();
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Idle after reset, stable for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_sout",  32'(a.sout),       32'd0);
            chk("rst_valid", 32'(a.sout_valid), 32'd0);
            chk("rst_last",  32'(a.sout_last),  32'd0);
            chk("rst_ready", 32'(a.load_ready), 32'd1);
        end

        // Single word 1011, MSB first; cycle k+5 back in idle.
        a.pdata = 4'b1011; a.load_valid = 1'b1;
        step();
        a.load_valid = 1'b0; a.pdata = '0;
        e_sout = 9'b0_1101; e_vld = 9'b0_1111; e_last = 9'b0_1000; e_rdy = 9'b1_1000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("one_sout",  32'(a.sout),       32'(e_sout[i]));
            chk("one_valid", 32'(a.sout_valid), 32'(e_vld[i]));
            chk("one_last",  32'(a.sout_last),  32'(e_last[i]));
            chk("one_ready", 32'(a.load_ready), 32'(e_rdy[i]));
        end

        // Back-to-back 1011 then 0110 with load_valid held.
        a.pdata = 4'b1011; a.load_valid = 1'b1;
        step();
        a.pdata = 4'b0110;
        // index i = cycle k+1+i; stream 1,0,1,1,0,1,1,0 then idle
        e_sout = 9'b0_0110_1101; e_vld = 9'b0_1111_1111;
        e_last = 9'b0_1000_1000; e_rdy = 9'b1_1000_1000;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("b2b_sout",  32'(a.sout),       32'(e_sout[i]));
            chk("b2b_valid", 32'(a.sout_valid), 32'(e_vld[i]));
            chk("b2b_last",  32'(a.sout_last),  32'(e_last[i]));
            chk("b2b_ready", 32'(a.load_ready), 32'(e_rdy[i]));
            if (i == 4) a.load_valid = 1'b0;
        end

        // Reset mid-word, with load_valid high in the reset edge.
        a.pdata = 4'b1111; a.load_valid = 1'b1;
        step();
        a.load_valid = 1'b0;
        step();
        rst_n = 1'b0; a.load_valid = 1'b1; a.pdata = 4'b0101;
        step();
        rst_n = 1'b1; a.load_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(a.sout_valid), 32'd0);
        chk("mid_rst_sout",  32'(a.sout),       32'd0);
        chk("mid_rst_ready", 32'(a.load_ready), 32'd1);
        a.pdata = 4'b0001; a.load_valid = 1'b1;
        step();
        a.load_valid = 1'b0;
        e_sout = 9'b0_1000; e_last = 9'b0_1000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_sout",  32'(a.sout),      32'(e_sout[i]));
            chk("post_rst_last",  32'(a.sout_last), 32'(e_last[i]));
        end

        // Sender holds load_valid while pdata churns every cycle.
        a.load_valid = 1'b1;
        repeat (40) begin
            a.pdata = 4'($urandom);
            step();
        end
        a.load_valid = 1'b0;
        repeat (6) step();

        // Random traffic with occasional resets.
        repeat (2000) begin
            a.load_valid = ($urandom % 4) != 0;
            a.pdata      = 4'($urandom);
            rst_n        = ($urandom % 150) != 0;
            step();
        end
        rst_n = 1'b1; a.load_valid = 1'b0;
        repeat (6) step();

        // 8-bit LSB-first: A5 goes out 1,0,1,0,0,1,0,1 and loops back.
        bits8 = '{1, 0, 1, 0, 0, 1, 0, 1};
        sipo  = '0;
        b.pdata = 8'hA5; b.load_valid = 1'b1;
        step();
        b.load_valid = 1'b0; b.pdata = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("w8_valid", 32'(b.sout_valid), 32'd1);
            chk("w8_sout",  32'(b.sout),       32'(bits8[i]));
            chk("w8_last",  32'(b.sout_last),  32'(i == 7));
            if (b.sout_valid) sipo = {b.sout, sipo[7:1]};
        end
        @(negedge clk);
        chk("w8_idle",     32'(b.sout_valid), 32'd0);
        chk("w8_loopback", 32'(sipo),         32'hA5);

        step();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/piso_reg_tx.md
Name: piso_reg_tx

Overview:
Parallel-in serial-out shift transmitter, the transmit end of the serial link whose receive end is our SIPO register. It accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per clock. A framing valid signal and a last-bit flag let a downstream SIPO capture exactly WIDTH bits. It supports back-to-back words with no idle gap.

Parameters:
WIDTH, 4, word width in bits (legal range 2..32)
MSB_FIRST, 1, 1 = bit WIDTH-1 is transmitted first; 0 = bit 0 is transmitted first

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk
pdata  in  WIDTH  parallel word to transmit
load_valid  in  1  pdata is valid; held until accepted
load_ready  out  1  block can accept a word this cycle
sout  out  1  serial data bit
sout_valid  out  1  sout carries a word bit this cycle
sout_last  out  1  current sout bit is the final bit of the word
busy  out  1  a word is in transmission (equals sout_valid)

Behaviour:
- Scope: one clock domain. Reset is synchronous and active-low: rst_n is sampled on the rising edge of clk.
- States: IDLE, SHIFT. State, shift register (WIDTH bits) and bit counter (clog2(WIDTH) bits) are registered.
- Reset (rst_n=0 at a rising edge):
  - state <= IDLE; shift register <= 0; counter <= 0.
  - Outputs after reset: sout=0, sout_valid=0, sout_last=0, busy=0, load_ready=1.
- Accept: a word is accepted at a rising edge where load_valid=1 and load_ready=1.
- Output decode (combinational from registered state):
  - load_ready = (state==IDLE) || (state==SHIFT && counter==WIDTH-1).
  - sout_valid = busy = (state==SHIFT).
  - sout_last = (state==SHIFT && counter==WIDTH-1).
  - sout = shift register bit WIDTH-1 when MSB_FIRST=1, bit 0 when MSB_FIRST=0; forced to 0 in IDLE.
- IDLE:
  - Accept at edge k: shift register <= pdata, counter <= 0, state <= SHIFT.
  - The first bit appears on sout in cycle k+1 (latency 1 cycle).
  - Otherwise remain in IDLE.
- SHIFT, counter < WIDTH-1:
  - Each edge shifts the register by one position toward the output end, zero-filled; counter increments.
  - load_valid is ignored here (load_ready=0); the sender holds pdata.
- SHIFT, counter == WIDTH-1 (final bit cycle):
  - With an accept: load pdata, counter <= 0, stay in SHIFT. The next word's first bit follows immediately, with no gap.
  - Without an accept: state <= IDLE, and the shift register clears to 0.
- Timing: a word occupies exactly WIDTH consecutive sout_valid cycles. Back-to-back throughput is one bit per clock.
- Reset mid-word: the word in flight is discarded, and the block returns to the reset state at that edge. A load_valid asserted in the same edge as reset is not accepted.
- pdata is sampled only at the accept edge; later changes to pdata do not affect the word in flight.
- X/unknown inputs are a don't-care outside the accept edge.

Test Plan:
- Reset/idle: hold rst_n=0 for 2 edges, release -> sout=0, sout_valid=0, sout_last=0, load_ready=1; these values are stable for 5 idle cycles.
- Single word, WIDTH=4, MSB_FIRST=1: accept pdata=4'b1011 at edge k -> sout 1,0,1,1 in cycles k+1..k+4; sout_last only in k+4; load_ready=0 in k+1..k+3; IDLE with sout_valid=0 in k+5.
- Back-to-back: 4'b1011 then 4'b0110, with load_valid held high -> 8 contiguous valid cycles, sout = 1,0,1,1,0,1,1,0; sout_last in cycles 4 and 8; second word accepted at the edge ending cycle 4.
- Hold during busy: keep load_valid=1 with pdata changing every cycle throughout word 1 -> no accept until the final-bit cycle; the second word equals the pdata value present at that edge.
- Reset mid-word: accept 4'b1111, assert rst_n=0 at the edge after bit 2 -> next cycle sout_valid=0, sout=0, load_ready=1; a fresh 4'b0001 then transmits correctly.
- Parameter sweep: WIDTH=8, MSB_FIRST=0, pdata=8'hA5 -> sout 1,0,1,0,0,1,0,1 (LSB first); loopback into an 8-bit SIPO gated by sout_valid reproduces 8'hA5.
